// File: rtl/risc16_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RiSC-16 datapath.
// Optional macro RISC16_HALT_EN: a JALR with nonzero ir[6:0] halts the core instead of jumping.
module risc16_seq_ctrl #(
    parameter int WIDTH       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ir,
    input  logic             mem_ack,
    input  logic             alu_zero,
    output logic             ir_load,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [2:0]       dest_reg,
    output logic [2:0]       first_operand,
    output logic [2:0]       second_operand,
    output logic             gpr_write_en,
    output logic [1:0]       wb_sel,
    output logic [2:0]       alu_op_code,
    output logic             alu_src_imm,
    output logic [WIDTH-1:0] imm,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_NAND   = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_CMP    = 3'b011;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

`ifdef RISC16_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_t           state;
    state_t           nxt_state;
    logic [2:0]       op_q;
    logic [2:0]       ra_q;
    logic [2:0]       rb_q;
    logic [2:0]       rc_q;
    logic [2:0]       nxt_op;
    logic [2:0]       nxt_ra;
    logic [2:0]       nxt_rb;
    logic [2:0]       nxt_rc;
    logic [WIDTH-1:0] nxt_imm;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    nxt_cnt;
    logic             req_ack;
    logic             wd_fire;
    logic             exec_halt;

    logic             pc_write_q;
    logic [1:0]       pc_src_q;
    logic             beq_q;
    logic             sw_ack_q;

    logic             d_mem_req;
    logic             d_mem_we;
    logic             d_mem_addr_sel;
    logic [2:0]       d_dest;
    logic [2:0]       d_first;
    logic [2:0]       d_second;
    logic             d_gpr_we;
    logic [1:0]       d_wb_sel;
    logic [2:0]       d_alu_op;
    logic             d_src_imm;
    logic             d_pc_write;
    logic [1:0]       d_pc_src;
    logic             d_beq;
    logic             d_sw_ack;
    logic             d_halt;

    // Instruction fields are captured only while leaving DECODE.
    always_comb begin
        nxt_op  = op_q;
        nxt_ra  = ra_q;
        nxt_rb  = rb_q;
        nxt_rc  = rc_q;
        nxt_imm = imm;
        if (state == DECODE) begin
            nxt_op = ir[15:13];
            nxt_ra = ir[12:10];
            nxt_rb = ir[9:7];
            nxt_rc = ir[2:0];
            if (ir[15:13] == OP_LUI) begin
                nxt_imm = {ir[9:0], {(WIDTH-10){1'b0}}};
            end else begin
                nxt_imm = {{(WIDTH-7){ir[6]}}, ir[6:0]};
            end
        end
    end

    assign req_ack   = mem_req & mem_ack;
    assign wd_fire   = (MEM_TIMEOUT != 0) && mem_req && !mem_ack && (cnt == LIMIT);
    assign exec_halt = HALT_EN && (imm[6:0] != 7'd0);

    always_comb begin
        nxt_state = state;
        case (state)
            FETCH: begin
                if (req_ack)      nxt_state = DECODE;
                else if (wd_fire) nxt_state = HALT;
            end
            DECODE: nxt_state = EXEC;
            EXEC: begin
                case (op_q)
                    OP_SW, OP_LW: nxt_state = MEM;
                    OP_BEQ:       nxt_state = FETCH;
                    OP_JALR:      nxt_state = exec_halt ? HALT : FETCH;
                    default:      nxt_state = WB;
                endcase
            end
            MEM: begin
                if (req_ack)      nxt_state = (op_q == OP_LW) ? WB : FETCH;
                else if (wd_fire) nxt_state = HALT;
            end
            WB:      nxt_state = FETCH;
            HALT:    nxt_state = HALT;
            default: nxt_state = HALT;
        endcase
    end

    always_comb begin
        nxt_cnt = '0;
        if ((MEM_TIMEOUT != 0) && mem_req && !mem_ack && !wd_fire) begin
            nxt_cnt = cnt + CW'(1);
        end
    end

    // Output decode for the state being entered; registering it keeps every
    // strobe glitch-free and lets reset clear them asynchronously.
    always_comb begin
        d_mem_req      = 1'b0;
        d_mem_we       = 1'b0;
        d_mem_addr_sel = 1'b0;
        d_dest         = 3'd0;
        d_first        = 3'd0;
        d_second       = 3'd0;
        d_gpr_we       = 1'b0;
        d_wb_sel       = 2'd0;
        d_alu_op       = ALU_ADD;
        d_src_imm      = 1'b0;
        d_pc_write     = 1'b0;
        d_pc_src       = 2'd0;
        d_beq          = 1'b0;
        d_sw_ack       = 1'b0;
        d_halt         = HALT_EN && (nxt_imm[6:0] != 7'd0);

        if (nxt_state == FETCH) begin
            d_mem_req = 1'b1;
        end

        // ALU selects stay driven from EXEC through WB so the result is stable at write-back.
        if (nxt_state == EXEC || nxt_state == MEM || nxt_state == WB) begin
            d_dest = nxt_ra;
            case (nxt_op)
                OP_ADD: begin
                    d_first  = nxt_rb;
                    d_second = nxt_rc;
                    d_alu_op = ALU_ADD;
                end
                OP_NAND: begin
                    d_first  = nxt_rb;
                    d_second = nxt_rc;
                    d_alu_op = ALU_NAND;
                end
                OP_ADDI: begin
                    d_first   = nxt_rb;
                    d_src_imm = 1'b1;
                    d_alu_op  = ALU_ADD;
                end
                OP_LUI: begin
                    d_src_imm = 1'b1;
                    d_alu_op  = ALU_PASS_B;
                end
                OP_SW, OP_LW: begin
                    d_first   = nxt_rb;
                    d_second  = nxt_ra;
                    d_src_imm = 1'b1;
                    d_alu_op  = ALU_ADD;
                end
                OP_BEQ: begin
                    d_first  = nxt_ra;
                    d_second = nxt_rb;
                    d_alu_op = ALU_CMP;
                end
                default: begin
                    d_second = nxt_rb;
                    d_alu_op = ALU_PASS_B;
                end
            endcase
        end

        case (nxt_state)
            EXEC: begin
                if (nxt_op == OP_BEQ) begin
                    d_pc_write = 1'b1;
                    d_beq      = 1'b1;
                end else if (nxt_op == OP_JALR && !d_halt) begin
                    d_gpr_we   = (nxt_ra != 3'd0);
                    d_wb_sel   = 2'd2;
                    d_pc_write = 1'b1;
                    d_pc_src   = 2'd2;
                end
            end
            MEM: begin
                d_mem_req      = 1'b1;
                d_mem_addr_sel = 1'b1;
                d_mem_we       = (nxt_op == OP_SW);
                d_sw_ack       = (nxt_op == OP_SW);
            end
            WB: begin
                d_gpr_we   = (nxt_ra != 3'd0);
                d_wb_sel   = (nxt_op == OP_LW) ? 2'd1 : 2'd0;
                d_pc_write = 1'b1;
                d_pc_src   = 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            op_q           <= 3'd0;
            ra_q           <= 3'd0;
            rb_q           <= 3'd0;
            rc_q           <= 3'd0;
            imm            <= '0;
            cnt            <= '0;
            halted         <= 1'b0;
            bus_err        <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr_sel   <= 1'b0;
            dest_reg       <= 3'd0;
            first_operand  <= 3'd0;
            second_operand <= 3'd0;
            gpr_write_en   <= 1'b0;
            wb_sel         <= 2'd0;
            alu_op_code    <= 3'd0;
            alu_src_imm    <= 1'b0;
            pc_write_q     <= 1'b0;
            pc_src_q       <= 2'd0;
            beq_q          <= 1'b0;
            sw_ack_q       <= 1'b0;
        end else begin
            state          <= nxt_state;
            op_q           <= nxt_op;
            ra_q           <= nxt_ra;
            rb_q           <= nxt_rb;
            rc_q           <= nxt_rc;
            imm            <= nxt_imm;
            cnt            <= nxt_cnt;
            halted         <= halted | (state == HALT);
            bus_err        <= bus_err | wd_fire;
            mem_req        <= d_mem_req;
            mem_we         <= d_mem_we;
            mem_addr_sel   <= d_mem_addr_sel;
            dest_reg       <= d_dest;
            first_operand  <= d_first;
            second_operand <= d_second;
            gpr_write_en   <= d_gpr_we;
            wb_sel         <= d_wb_sel;
            alu_op_code    <= d_alu_op;
            alu_src_imm    <= d_src_imm;
            pc_write_q     <= d_pc_write;
            pc_src_q       <= d_pc_src;
            beq_q          <= d_beq;
            sw_ack_q       <= d_sw_ack;
        end
    end

    // The few strobes that must react to the handshake or the compare within the same cycle.
    assign ir_load  = (state == FETCH) & req_ack;
    assign pc_write = pc_write_q | (sw_ack_q & mem_ack);
    assign pc_src   = beq_q ? {1'b0, alu_zero} : pc_src_q;

endmodule

// File: tb/tb_risc16_seq_ctrl.sv
// Randomized self-checking bench for risc16_seq_ctrl against an instruction-level timing/effect model.
// Also exercises RISC16_HALT_EN when that macro is defined for the build.
module tb_risc16_seq_ctrl;

    localparam int WIDTH       = 16;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      ir;
    logic             mem_ack;
    logic             alu_zero;
    logic             ir_load;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic [2:0]       dest_reg;
    logic [2:0]       first_operand;
    logic [2:0]       second_operand;
    logic             gpr_write_en;
    logic [1:0]       wb_sel;
    logic [2:0]       alu_op_code;
    logic             alu_src_imm;
    logic [WIDTH-1:0] imm;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             halted;
    logic             bus_err;

    int nChecks = 0;
    int nFails  = 0;

    risc16_seq_ctrl #(.WIDTH(WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .dest_reg(dest_reg), .first_operand(first_operand), .second_operand(second_operand),
        .gpr_write_en(gpr_write_en), .wb_sel(wb_sel), .alu_op_code(alu_op_code),
        .alu_src_imm(alu_src_imm), .imm(imm), .pc_write(pc_write), .pc_src(pc_src),
        .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] modelImm(input logic [15:0] w);
        logic [15:0] lo7;
        lo7 = {9'd0, w[6:0]};
        if (w[15:13] == OP_LUI) return {6'd0, w[9:0]} * 16'd64;
        else if (w[6])          return lo7 - 16'd128;
        else                    return lo7;
    endfunction

    function automatic int modelCycles(input logic [2:0] op, input int fw, input int mw);
        case (op)
            OP_BEQ, OP_JALR: return 3 + fw;
            OP_LW:           return 5 + fw + mw;
            OP_SW:           return 4 + fw + mw;
            default:         return 4 + fw;
        endcase
    endfunction

    function automatic logic [2:0] modelAlu(input logic [2:0] op);
        case (op)
            OP_NAND:         return 3'b001;
            OP_LUI, OP_JALR: return 3'b010;
            OP_BEQ:          return 3'b011;
            default:         return 3'b000;
        endcase
    endfunction

    task automatic applyReset();
        rst_n    = 1'b0;
        mem_ack  = 1'b1;
        ir       = 16'h0000;
        alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_req", 32'(mem_req), 0);
        checkOutput("rst_ir_load", 32'(ir_load), 0);
        checkOutput("rst_strobes", 32'({gpr_write_en, pc_write, mem_we}), 0);
        checkOutput("rst_status", 32'({halted, bus_err}), 0);
        checkOutput("rst_imm", 32'(imm), 0);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 8 && !mem_req; i++) @(negedge clk);
        checkOutput("rst_fetch_req", 32'({mem_req, mem_addr_sel}), 32'b10);
    endtask

    // Runs one instruction from its first FETCH cycle until the next FETCH begins.
    task automatic applyStimulus(input logic [15:0] instr, input int fw, input int mw, input logic zero);
        logic [2:0] op, ra, rb, rc;
        int         cyc, phaseCnt, irLoads, gprW, pcW, weCyc, memSelCyc, expW;
        logic [2:0] dst, aluOp, firstOp, secOp;
        logic [1:0] wbs, pcs;
        logic       srcImm, loaded, done;
        op = instr[15:13]; ra = instr[12:10]; rb = instr[9:7]; rc = instr[2:0];
        cyc = 0; phaseCnt = 0; irLoads = 0; gprW = 0; pcW = 0; weCyc = 0; memSelCyc = 0;
        dst = 0; aluOp = 0; firstOp = 0; secOp = 0; wbs = 0; pcs = 0; srcImm = 0;
        loaded = 0; done = 0;
        while (!done && cyc < 64) begin
            if (loaded && mem_req && !mem_addr_sel) begin
                done = 1;
            end else begin
                cyc++;
                ir = instr;
                alu_zero = zero;
                if (mem_req) begin
                    mem_ack = (phaseCnt == (mem_addr_sel ? mw : fw));
                    phaseCnt++;
                    if (mem_addr_sel) memSelCyc++;
                end else begin
                    phaseCnt = 0;
                    mem_ack = 1'($urandom_range(0, 1));
                end
                if (mem_we) weCyc++;
                #1;
                if (ir_load) begin irLoads++; loaded = 1; end
                if (gpr_write_en) begin gprW++; dst = dest_reg; wbs = wb_sel; end
                if (pc_write) begin
                    pcW++; pcs = pc_src; aluOp = alu_op_code; srcImm = alu_src_imm;
                    firstOp = first_operand; secOp = second_operand;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            checkOutput("instr_timeout", 32'(cyc), 32'(modelCycles(op, fw, mw)));
            return;
        end
        expW = ((op != OP_SW && op != OP_BEQ) && ra != 3'd0) ? 1 : 0;
        checkOutput("cycles", 32'(cyc), 32'(modelCycles(op, fw, mw)));
        checkOutput("ir_load_count", 32'(irLoads), 1);
        checkOutput("imm", 32'(imm), 32'(modelImm(instr)));
        checkOutput("gpr_write_count", 32'(gprW), 32'(expW));
        if (expW == 1) begin
            checkOutput("dest_reg", 32'(dst), 32'(ra));
            checkOutput("wb_sel", 32'(wbs), (op == OP_LW) ? 1 : (op == OP_JALR) ? 2 : 0);
        end
        checkOutput("pc_write_count", 32'(pcW), 1);
        checkOutput("pc_src", 32'(pcs), (op == OP_BEQ) ? 32'(zero) : (op == OP_JALR) ? 2 : 0);
        checkOutput("alu_op", 32'(aluOp), 32'(modelAlu(op)));
        checkOutput("alu_src_imm", 32'(srcImm),
                    (op == OP_ADDI || op == OP_LUI || op == OP_LW || op == OP_SW) ? 1 : 0);
        checkOutput("mem_we_cycles", 32'(weCyc), (op == OP_SW) ? mw + 1 : 0);
        checkOutput("mem_sel_cycles", 32'(memSelCyc), (op == OP_SW || op == OP_LW) ? mw + 1 : 0);
        if (op == OP_ADD || op == OP_NAND) begin
            checkOutput("operands", 32'({firstOp, secOp}), 32'({rb, rc}));
        end else if (op == OP_BEQ) begin
            checkOutput("operands", 32'({firstOp, secOp}), 32'({ra, rb}));
        end else if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin
            checkOutput("base_operand", 32'(firstOp), 32'(rb));
        end else if (op == OP_JALR) begin
            checkOutput("jalr_operand", 32'(secOp), 32'(rb));
        end
    endtask

    logic [15:0] instr;
    int          reqCyc, pcW;
    logic        seenErr, found;

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; ir = 16'h0; alu_zero = 1'b0;
        applyReset();

        applyStimulus(16'h0503, 0, 0, 1'b0);   // ADD r1,r2,r3
        applyStimulus(16'h2085, 0, 0, 1'b0);   // ADDI r0,r1,5
        applyStimulus(16'hA9FF, 0, 2, 1'b0);   // LW r2,r3,-1 with two wait states
        applyStimulus(16'hC484, 0, 0, 1'b1);   // BEQ taken
        applyStimulus(16'hC484, 0, 0, 1'b0);   // BEQ not taken
        applyStimulus(16'h6EAB, 1, 0, 1'b0);   // LUI r3,0x2AB
        applyStimulus(16'h8503, 0, 1, 1'b0);   // SW r1,r2,3
`ifndef RISC16_HALT_EN
        applyStimulus(16'hE001, 0, 0, 1'b0);   // JALR with nonzero low bits jumps normally
`endif

        for (int n = 0; n < 40; n++) begin
            instr = 16'($urandom);
`ifdef RISC16_HALT_EN
            if (instr[15:13] == OP_JALR) instr[6:0] = 7'd0;
`endif
            applyStimulus(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        // Async reset while a store is waiting in MEM.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            ir = 16'h8503;
            if (mem_req && mem_addr_sel) found = 1'b1;
            else begin
                mem_ack = mem_req;
                @(negedge clk);
            end
        end
        checkOutput("mid_mem_reached", 32'(found), 1);
        checkOutput("mid_mem_we", 32'(mem_we), 1);
        mem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_mem_req", 32'(mem_req), 0);
        checkOutput("rst_async_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8 && !mem_req; i++) @(negedge clk);
        checkOutput("post_rst_fetch", 32'({mem_req, mem_addr_sel}), 32'b10);
        checkOutput("post_rst_status", 32'({halted, bus_err}), 0);

        // Watchdog: no ack at all in FETCH.
        applyReset();
        reqCyc = 0; seenErr = 1'b0;
        for (int i = 0; i < 40 && !seenErr; i++) begin
            mem_ack = 1'b0;
            if (bus_err) seenErr = 1'b1;
            else begin
                if (mem_req) reqCyc++;
                @(negedge clk);
            end
        end
        checkOutput("wd_bus_err", 32'(seenErr), 1);
        checkOutput("wd_req_cycles", 32'(reqCyc), MEM_TIMEOUT);
        checkOutput("wd_halted_lag", 32'(halted), 0);
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        checkOutput("wd_halted", 32'(halted), 1);
        checkOutput("wd_strobes", 32'({mem_req, mem_we, gpr_write_en, pc_write, ir_load}), 0);
        checkOutput("wd_bus_err_sticky", 32'(bus_err), 1);
        @(negedge clk);

        // Ack on the very cycle the limit is reached.
        applyReset();
        applyStimulus(16'h0503, MEM_TIMEOUT - 1, 0, 1'b0);
        checkOutput("wd_ack_wins", 32'({bus_err, halted}), 0);

`ifdef RISC16_HALT_EN
        applyReset();
        pcW = 0;
        for (int i = 0; i < 10; i++) begin
            ir = 16'hE001;
            mem_ack = mem_req;
            #1;
            if (pc_write) pcW++;
            @(negedge clk);
        end
        checkOutput("halt_en_pc_write", 32'(pcW), 0);
        checkOutput("halt_en_halted", 32'(halted), 1);
        checkOutput("halt_en_bus_err", 32'(bus_err), 0);
        checkOutput("halt_en_mem_req", 32'(mem_req), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
